// File: rtl/add_seq_ctrl.sv
// Sequential nibble-serial adder/subtractor.
// One 4-bit carry-lookahead slice is reused across all nibbles, LSB first.
module add_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] Sum,
    output logic                 Cout,
    output logic                 Ovfl,
    output logic                 Zero,
    output logic                 Neg
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [NIBBLES-1:0][3:0] a_q, b_q, sum_q;
    logic [IW-1:0]           idx_q;
    logic                    cy_q, cout_q, ovfl_q;

    logic [3:0] a_nib, b_nib, g, p, s;
    logic [4:0] c;
    logic       last, accept;

    assign last   = (idx_q == LAST);
    assign accept = (state_q == IDLE) && in_valid && !clr;

    assign a_nib = a_q[idx_q];
    assign b_nib = b_q[idx_q];
    assign g     = a_nib & b_nib;
    assign p     = a_nib ^ b_nib;

    assign c[0] = cy_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign s    = p ^ c[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx_q  <= '0;
            cy_q   <= 1'b0;
            cout_q <= 1'b0;
            ovfl_q <= 1'b0;
        end else if (clr) begin
            idx_q <= '0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B ^ {W{sub}};
            cy_q  <= sub;
            idx_q <= '0;
            sum_q <= '0;
        end else if (state_q == BUSY) begin
            sum_q[idx_q] <= s;
            cy_q         <= c[4];
            if (last) begin
                cout_q <= c[4];
                ovfl_q <= c[4] ^ c[3];
                idx_q  <= '0;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovfl      = ovfl_q;
    assign Zero      = (sum_q == '0);
    assign Neg       = sum_q[NIBBLES-1][3];

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: directed vectors, stall, reset and clr.
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_add_seq_ctrl;

    logic        clk, rst_n, clr, in_valid, in_ready, sub;
    logic        out_valid, out_ready, Cout, Ovfl, Zero, Neg;
    logic [15:0] A, B, Sum;

    add_seq_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovfl(Ovfl), .Zero(Zero), .Neg(Neg)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   prev_ov = 0;

    vec_t vecs[8] = '{
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
        '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0},
        '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
        '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0},
        '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0},
        '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout expected out_valid", name);
    endtask

    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 32'(cyc - e.acc), 32'd4);
                chk("sum", 32'(Sum), 32'(e.sum));
                chk("cout", 32'(Cout), 32'(e.c));
                chk("ovfl", 32'(Ovfl), 32'(e.v));
                chk("zero", 32'(Zero), 32'(e.z));
                chk("neg", 32'(Neg), 32'(e.n));
            end
        end
        prev_ov = out_valid;
    end

    task automatic wait_valid(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        if (!got) timeout(name);
    endtask

    task automatic do_op(input vec_t t);
        exp_t e;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        A        = t.a;
        B        = t.b;
        sub      = t.s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e = '{sum: t.sum, c: t.c, v: t.v, z: t.z, n: t.n, acc: cyc};
        q.push_back(e);
        in_valid = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        sub      = 1'($urandom);
        wait_valid("op_done");
        @(posedge clk);
    endtask

    task automatic start_abortable;
        @(negedge clk);
        A        = 16'h0F0F;
        B        = 16'h0101;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        sub       = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_neg", 32'(Neg), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_ovfl", 32'(Ovfl), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i]);

        // Stall in DONE while in_valid toggles with fresh operands.
        @(negedge clk);
        A         = 16'h1111;
        B         = 16'h2222;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        e = '{sum: 16'h3333, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0, acc: cyc};
        q.push_back(e);
        in_valid = 1'b0;
        wait_valid("stall_done");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_sum", 32'(Sum), 32'h3333);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            in_valid = ~in_valid;
            A        = 16'($urandom);
            B        = 16'($urandom);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("retain_sum", 32'(Sum), 32'h3333);

        // Asynchronous reset with idx at 2.
        start_abortable();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", 32'(Sum), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_zero", 32'(Zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Synchronous clr with idx at 2.
        start_abortable();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        clr = 1'b0;
        repeat (8) @(negedge clk);

        do_op('{16'h0001, 16'h0001, 1'b0, 16'h0002,
                1'b0, 1'b0, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
